// File: rtl/ctrl_pkg.sv
// Shared state encoding for the layer sequencer.
// Also imported by the testbench so both sides use the same codes.
package ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 3'd0,
    S_REST    = 3'd1,
    S_READ_W  = 3'd2,
    S_READ_I  = 3'd3,
    S_COMPUTE = 3'd4,
    S_OUTPUT  = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  function automatic logic is_phase(input state_t s);
    return (s == S_READ_W) || (s == S_READ_I) ||
           (s == S_COMPUTE) || (s == S_OUTPUT);
  endfunction

endpackage

// File: rtl/layer_seq_ctrl_phase_timer.sv
// Per-phase watchdog counter.
// Flags expiry on the last allowed cycle of a phase.
module phase_timer #(
  parameter int TMR_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST =
    TMR_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

endmodule

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: REST, per-layer weight/input/compute
// phases, final output phase, watchdog and sticky error.
module layer_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int REST_CYCLES    = 11,
  parameter int NUM_LAYERS     = 2,
  parameter int LAYER_W        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic               read_weights_finish,
  input  logic               read_inputs_finish,
  input  logic               compute_finish,
  input  logic               output_finish,
  output logic               start_read_w,
  output logic               start_read_i,
  output logic               start_compute,
  output logic               start_output,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_phase,
  output logic [2:0]         state_o
);

  localparam int RC_W = $clog2(REST_CYCLES + 1);
  localparam logic [RC_W-1:0] REST_LAST = RC_W'(REST_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [LAYER_W-1:0] LY_ONE = LAYER_W'(1);

  state_t          state;
  state_t          state_nx;
  logic [RC_W-1:0] rest_cnt;
  logic            wd_exp;
  logic            wd_clr;
  logic            in_phase;
  logic            more_layers;

  assign in_phase    = is_phase(state);
  assign more_layers = layer_idx < LAST_LAYER;
  assign wd_clr      = (state_nx != state) || abort;

  phase_timer #(
    .TMR_W          (TMR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (in_phase),
    .expired (wd_exp)
  );

  // A finish in the expiry cycle takes precedence over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (go) state_nx = S_REST;
      end
      S_REST: begin
        if (rest_cnt == REST_LAST) state_nx = S_READ_W;
      end
      S_READ_W: begin
        if (read_weights_finish)
          state_nx = (layer_idx == '0) ? S_READ_I : S_COMPUTE;
        else if (wd_exp)
          state_nx = S_ERROR;
      end
      S_READ_I: begin
        if (read_inputs_finish) state_nx = S_COMPUTE;
        else if (wd_exp) state_nx = S_ERROR;
      end
      S_COMPUTE: begin
        if (compute_finish)
          state_nx = more_layers ? S_READ_W : S_OUTPUT;
        else if (wd_exp)
          state_nx = S_ERROR;
      end
      S_OUTPUT: begin
        if (output_finish) state_nx = S_IDLE;
        else if (wd_exp) state_nx = S_ERROR;
      end
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      layer_idx <= '0;
      rest_cnt  <= '0;
      done      <= 1'b0;
      err_phase <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == S_OUTPUT) && output_finish && !abort;
      if (abort) begin
        layer_idx <= '0;
        rest_cnt  <= '0;
        err_phase <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              layer_idx <= '0;
              rest_cnt  <= '0;
            end
          end
          S_REST: rest_cnt <= rest_cnt + RC_ONE;
          S_COMPUTE: begin
            if (compute_finish && more_layers)
              layer_idx <= layer_idx + LY_ONE;
          end
          S_OUTPUT: begin
            if (output_finish) layer_idx <= '0;
          end
          default: ;
        endcase
        if (state_nx == S_ERROR && state != S_ERROR)
          err_phase <= state;
      end
    end
  end

  assign start_read_w  = (state == S_READ_W);
  assign start_read_i  = (state == S_READ_I);
  assign start_compute = (state == S_COMPUTE);
  assign start_output  = (state == S_OUTPUT);
  assign busy          = (state != S_IDLE) && (state != S_ERROR);
  assign err           = (state == S_ERROR);
  assign state_o       = state;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: default build plus a
// single-layer build with a short watchdog.
module tb_layer_seq_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic ra, ga, aa, a_fw, a_fi, a_fc, a_fo;
  logic a_sw, a_si, a_sc, a_so, a_busy, a_done, a_err;
  logic [1:0] a_layer;
  logic [2:0] a_ep, a_st;

  logic rb, gb, ab, b_fw, b_fi, b_fc, b_fo;
  logic b_sw, b_si, b_sc, b_so, b_busy, b_done, b_err;
  logic [0:0] b_layer;
  logic [2:0] b_ep, b_st;

  layer_seq_ctrl u_a (
    .clk(clk), .rst(ra), .go(ga), .abort(aa),
    .read_weights_finish(a_fw), .read_inputs_finish(a_fi),
    .compute_finish(a_fc), .output_finish(a_fo),
    .start_read_w(a_sw), .start_read_i(a_si),
    .start_compute(a_sc), .start_output(a_so),
    .layer_idx(a_layer), .busy(a_busy), .done(a_done),
    .err(a_err), .err_phase(a_ep), .state_o(a_st)
  );

  layer_seq_ctrl #(
    .REST_CYCLES(3), .NUM_LAYERS(1), .LAYER_W(1),
    .TIMEOUT_CYCLES(8), .TMR_W(4)
  ) u_b (
    .clk(clk), .rst(rb), .go(gb), .abort(ab),
    .read_weights_finish(b_fw), .read_inputs_finish(b_fi),
    .compute_finish(b_fc), .output_finish(b_fo),
    .start_read_w(b_sw), .start_read_i(b_si),
    .start_compute(b_sc), .start_output(b_so),
    .layer_idx(b_layer), .busy(b_busy), .done(b_done),
    .err(b_err), .err_phase(b_ep), .state_o(b_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clr_fin();
    a_fw = 0; a_fi = 0; a_fc = 0; a_fo = 0;
  endtask

  task automatic a_set_fin(input logic [2:0] st);
    case (st)
      S_READ_W:  a_fw = 1;
      S_READ_I:  a_fi = 1;
      S_COMPUTE: a_fc = 1;
      S_OUTPUT:  a_fo = 1;
      default: ;
    endcase
  endtask

  task automatic a_phase(input logic [2:0] st, input logic [1:0] ly,
                         input string nm);
    logic [3:0] es;
    case (st)
      S_READ_W:  es = 4'b1000;
      S_READ_I:  es = 4'b0100;
      S_COMPUTE: es = 4'b0010;
      S_OUTPUT:  es = 4'b0001;
      default:   es = 4'b0000;
    endcase
    n_chk++;
    if ({a_st, a_layer, a_sw, a_si, a_sc, a_so} !== {st, ly, es}) begin
      n_fail++;
      $display("FAIL %s entry: st=%0d ly=%0d start=%b, want st=%0d ly=%0d start=%b",
               nm, a_st, a_layer, {a_sw, a_si, a_sc, a_so}, st, ly, es);
    end
    tick();
    tick();
    n_chk++;
    if (a_st !== st || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s hold: st=%0d busy=%b, want st=%0d busy=1",
               nm, a_st, a_busy, st);
    end
    a_set_fin(st);
    tick();
    a_clr_fin();
  endtask

  task automatic a_rest(input string nm);
    int n;
    ga = 1;
    tick();
    ga = 0;
    n = 0;
    while (a_st == S_REST && n < 40) begin
      n++;
      tick();
    end
    n_chk++;
    if (n !== 11) begin
      n_fail++;
      $display("FAIL %s rest_len: got %0d cycles, want 11", nm, n);
    end
  endtask

  task automatic a_full_run(input string nm);
    a_rest(nm);
    a_phase(S_READ_W, 2'd0, {nm, "_W0"});
    a_phase(S_READ_I, 2'd0, {nm, "_I"});
    a_phase(S_COMPUTE, 2'd0, {nm, "_C0"});
    a_phase(S_READ_W, 2'd1, {nm, "_W1"});
    a_phase(S_COMPUTE, 2'd1, {nm, "_C1"});
    a_phase(S_OUTPUT, 2'd1, {nm, "_OUT"});
    n_chk++;
    if ({a_st, a_done, a_busy, a_err} !== {S_IDLE, 3'b100}) begin
      n_fail++;
      $display("FAIL %s done: st=%0d done=%b busy=%b err=%b, want st=0 done=1 busy=0 err=0",
               nm, a_st, a_done, a_busy, a_err);
    end
    tick();
    n_chk++;
    if (a_done !== 1'b0 || a_st !== S_IDLE) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b st=%0d, want done=0 st=0",
               nm, a_done, a_st);
    end
  endtask

  task automatic test_reset();
    ra = 1; rb = 1;
    ga = 0; aa = 0; gb = 0; ab = 0;
    a_clr_fin();
    b_fw = 0; b_fi = 0; b_fc = 0; b_fo = 0;
    tick();
    tick();
    ra = 0; rb = 0;
    n_chk++;
    if ({a_sw, a_si, a_sc, a_so, a_busy, a_done, a_err, a_ep, a_st, a_layer} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: outputs=%b, want all 0",
               {a_sw, a_si, a_sc, a_so, a_busy, a_done, a_err, a_ep, a_st, a_layer});
    end
    n_chk++;
    if ({b_sw, b_si, b_sc, b_so, b_busy, b_done, b_err, b_ep, b_st, b_layer} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: outputs=%b, want all 0",
               {b_sw, b_si, b_sc, b_so, b_busy, b_done, b_err, b_ep, b_st, b_layer});
    end
  endtask

  task automatic test_two_layers();
    a_full_run("run1");
  endtask

  task automatic test_held_finish();
    int n;
    logic [2:0] seq [4];
    seq = '{S_READ_W, S_READ_I, S_COMPUTE, S_OUTPUT};
    b_fw = 1; b_fi = 1; b_fc = 1; b_fo = 1;
    tick();
    gb = 1;
    tick();
    gb = 0;
    n = 0;
    while (b_st == S_REST && n < 20) begin
      n++;
      tick();
    end
    n_chk++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL held_rest: got %0d cycles, want 3", n);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (b_st !== seq[i] || b_layer !== 1'b0) begin
        n_fail++;
        $display("FAIL held_step%0d: st=%0d ly=%0d, want st=%0d ly=0",
                 i, b_st, b_layer, seq[i]);
      end
      tick();
    end
    n_chk++;
    if (b_st !== S_IDLE || b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_done: st=%0d done=%b busy=%b, want st=0 done=1 busy=0",
               b_st, b_done, b_busy);
    end
    b_fw = 0; b_fi = 0; b_fc = 0; b_fo = 0;
    tick();
  endtask

  task automatic b_to_compute(input string nm);
    int n;
    b_fw = 1; b_fi = 1; b_fc = 0; b_fo = 1;
    gb = 1;
    tick();
    gb = 0;
    n = 0;
    while (b_st != S_COMPUTE && n < 30) begin
      n++;
      tick();
    end
    n_chk++;
    if (b_st !== S_COMPUTE) begin
      n_fail++;
      $display("FAIL %s reach_compute: st=%0d, want 4", nm, b_st);
    end
  endtask

  task automatic test_timeout();
    int n;
    b_to_compute("tmo");
    n = 0;
    while (b_st == S_COMPUTE && n < 40) begin
      n++;
      tick();
    end
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL tmo_len: got %0d compute cycles, want 8", n);
    end
    n_chk++;
    if ({b_st, b_err, b_ep, b_sc, b_busy} !== {S_ERROR, 1'b1, 3'd4, 2'b00}) begin
      n_fail++;
      $display("FAIL tmo_err: st=%0d err=%b ep=%0d sc=%b busy=%b, want 6 1 4 0 0",
               b_st, b_err, b_ep, b_sc, b_busy);
    end
    gb = 1;
    tick();
    gb = 0;
    tick();
    n_chk++;
    if (b_st !== S_ERROR || b_err !== 1'b1 || b_ep !== 3'd4) begin
      n_fail++;
      $display("FAIL tmo_go_ignored: st=%0d err=%b ep=%0d, want 6 1 4",
               b_st, b_err, b_ep);
    end
    ab = 1;
    tick();
    ab = 0;
    n_chk++;
    if (b_st !== S_IDLE || b_err !== 1'b0 || b_ep !== 3'd0) begin
      n_fail++;
      $display("FAIL tmo_abort: st=%0d err=%b ep=%0d, want 0 0 0",
               b_st, b_err, b_ep);
    end
  endtask

  task automatic test_finish_at_expiry();
    b_to_compute("exp");
    repeat (7) tick();
    n_chk++;
    if (b_st !== S_COMPUTE || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_pre: st=%0d err=%b, want 4 0", b_st, b_err);
    end
    b_fc = 1;
    tick();
    b_fc = 0;
    n_chk++;
    if (b_st !== S_OUTPUT || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_advance: st=%0d err=%b, want 5 0", b_st, b_err);
    end
    tick();
    n_chk++;
    if (b_st !== S_IDLE || b_done !== 1'b1 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_done: st=%0d done=%b err=%b, want 0 1 0",
               b_st, b_done, b_err);
    end
    b_fw = 0; b_fi = 0; b_fo = 0;
    tick();
  endtask

  task automatic test_abort();
    a_rest("abt");
    a_fw = 1;
    tick();
    a_fw = 0;
    n_chk++;
    if (a_st !== S_READ_I) begin
      n_fail++;
      $display("FAIL abt_read_i: st=%0d, want 3", a_st);
    end
    a_fi = 1;
    aa = 1;
    tick();
    aa = 0;
    a_fi = 0;
    n_chk++;
    if ({a_st, a_layer, a_done, a_busy, a_si} !== {S_IDLE, 2'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL abt_idle: st=%0d ly=%0d done=%b busy=%b si=%b, want 0 0 0 0 0",
               a_st, a_layer, a_done, a_busy, a_si);
    end
    tick();
    n_chk++;
    if (a_done !== 1'b0 || a_st !== S_IDLE) begin
      n_fail++;
      $display("FAIL abt_no_done: done=%b st=%0d, want 0 0", a_done, a_st);
    end
    a_full_run("run2");
  endtask

  task automatic test_rst_mid_run();
    int n;
    ga = 1;
    tick();
    ga = 0;
    n = 0;
    while (!(a_st == S_COMPUTE && a_layer == 2'd1) && n < 100) begin
      n++;
      a_set_fin(a_st);
      tick();
      a_clr_fin();
    end
    n_chk++;
    if (a_st !== S_COMPUTE || a_layer !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_reach_c1: st=%0d ly=%0d, want 4 1", a_st, a_layer);
    end
    ra = 1;
    tick();
    ra = 0;
    n_chk++;
    if ({a_sw, a_si, a_sc, a_so, a_busy, a_done, a_err, a_ep, a_st, a_layer} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: outputs=%b, want all 0",
               {a_sw, a_si, a_sc, a_so, a_busy, a_done, a_err, a_ep, a_st, a_layer});
    end
    a_fw = 1; a_fi = 1; a_fc = 1; a_fo = 1;
    tick();
    tick();
    n_chk++;
    if ({a_st, a_busy, a_done, a_sw, a_si, a_sc, a_so} !== '0) begin
      n_fail++;
      $display("FAIL rst_stray: st=%0d busy=%b done=%b starts=%b, want all 0",
               a_st, a_busy, a_done, {a_sw, a_si, a_sc, a_so});
    end
    a_clr_fin();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_two_layers();
    test_held_finish();
    test_timeout();
    test_finish_at_expiry();
    test_abort();
    test_rst_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
